hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised, sequential successor to the decode stage's load-use stall logic.
- Keeps a per-register countdown of cycles until an in-flight result can be forwarded into decode. From it, the block generates RAW and WAW stalls for producers of any latency: ALU ops, loads, multi-cycle MUL.
- Sits beside decode. Decode presents each candidate instruction's sources, destination and producer latency; the block returns stall and records accepted issues.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is never busy.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- NUM_SRC, 2, source operands checked per instruction.
- CNT_W, 3, counter width; maximum latency is 2**CNT_W-1.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_we  in  1  the instruction writes a register.
- issue_dest  in  ADDR_W  destination register.
- issue_lat  in  CNT_W  cycles until the result is forwardable; 0 means forwardable next cycle (ALU op).
- src_valid  in  NUM_SRC  per-source "operand actually read".
- src_addr  in  NUM_SRC*ADDR_W  packed source addresses; source i is in bits [i*ADDR_W +: ADDR_W].
- squash_prev  in  1  cancel the write accepted in the previous cycle (branch/exception kill in EX).
- stall  out  1  combinational; hold decode and do not accept the issue.
- busy_vec  out  NUM_REGS  bit r = counter[r] != 0.
- issue_accept  out  1  issue_valid & ~stall.

Behaviour:
- State: cnt[NUM_REGS] of CNT_W bits each; last_we (1 bit); last_dest (ADDR_W bits).
- Reset (rst=0 at a clk edge): all cnt=0, last_we=0, last_dest=0. Therefore busy_vec=0, stall=0, issue_accept=issue_valid.
- RAW hazard: for any i, src_valid[i] & src_addr[i]!=0 & cnt[src_addr[i]]!=0.
- WAW hazard: issue_we & issue_dest!=0 & cnt[issue_dest] > issue_lat. This prevents a younger write completing before an older one.
- stall = issue_valid & (RAW | WAW). It depends only on current state and inputs, with no register in the path.
- Per-cycle update, in priority order (later steps override earlier ones):
  1. Every cnt!=0 decrements by 1; a counter never goes below 0.
  2. If squash_prev & last_we: cnt[last_dest] <= 0.
  3. If issue_accept & issue_we & issue_dest!=0: cnt[issue_dest] <= issue_lat.
- Latency semantics: a consumer of a lat=L producer stalls exactly L cycles when it immediately follows the producer. A lat=0 producer never causes a stall.
- last_we <= issue_accept & issue_we & issue_dest!=0; last_dest <= issue_dest. Both update every cycle.
- Simultaneous events:
  - Issue to a register whose counter is decrementing to 0 in the same cycle: the new value wins.
  - squash_prev and an issue to the same register in the same cycle: the issue wins.
  - squash_prev while last_we=0: no effect.
- Out-of-range addresses (>= NUM_REGS) are treated as register 0: never busy, never written.
- Reset mid-operation discards all pending counts; no partial state survives.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_LLSC_EN.
- Defined: adds inputs issue_ll, issue_sc, link_clear (exception/eret) and output sc_fail, plus a 2-state FSM:
  - IDLE -> LINKED on issue_accept & issue_ll.
  - LINKED -> IDLE on issue_accept & issue_sc, or on link_clear. link_clear has priority over a same-cycle LL.
  - sc_fail = issue_sc & (state==IDLE), combinational.
  - Reset state is IDLE.
- Undefined: none of these ports exist, and no FSM logic is built.

Decomposition:
- Shared package hazard_pkg holds:
  - Latency constants: LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3.
  - Register-zero constant.
  - LL/SC state encoding: IDLE=0, LINKED=1.
- One natural sub-module: hazard_cnt_cell, a single register's saturating counter with load and clear. It is instantiated NUM_REGS times via generate.

Test Plan:
- Reset, then cycle 0: issue lw r8 (lat=1, accepted). Cycle 1: issue add reading src r8. Required: stall=1 in cycle 1; busy_vec[8]=1 in cycle 1 and 0 in cycle 2; stall=0 in cycle 2.
- Issue mul r9 (lat=3). The next instruction reads r9. Required: stall high for exactly 3 cycles, then issue_accept=1.
- mul r10 (lat=3) followed by addu r10 (lat=0, WAW). Required: stall=1 until cnt[10]=0, then accept.
- Issue lw r5 (lat=1), then assert squash_prev next cycle while issuing an unrelated instruction. Required: cnt[5] clears to 0, and a reader of r5 the cycle after is not stalled.
- src_addr=0 with src_valid=1 after an issue of lat=3 to dest 0. Required: stall=0 throughout; busy_vec stays 0.
- With HAZARD_SCOREBOARD_LLSC_EN defined:
  - ll, then sc: sc_fail=0.
  - ll, link_clear, sc: sc_fail=1.
  - sc with no prior ll: sc_fail=1.
  - rst=0 while LINKED, then sc: sc_fail=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the decode-side hazard scoreboard.
// Producer latencies, the hard-wired zero register and the LL/SC link-state encoding.
package hazard_pkg;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;

    localparam int REG_ZERO = 0;

    typedef enum logic {
        LL_IDLE   = 1'b0,
        LL_LINKED = 1'b1
    } ll_state_t;

endpackage

// File: rtl/hazard_cnt_cell.sv
// One register's countdown: cycles left until its in-flight result is forwardable.
// Latency: load/clear take effect on the next clk edge; busy is combinational from the count.
// Backpressure: none; load beats clear beats the saturating decrement.
module hazard_cnt_cell
    import hazard_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW/WAW stall generation from per-register forwarding countdowns (LL/SC link tracking under HAZARD_SCOREBOARD_LLSC_EN).
// Latency: stall and issue_accept are combinational; accepted issues land in the counters at the next clk edge.
// Backpressure: stall holds decode; nothing is recorded for an instruction that is not accepted.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int CNT_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic                      issue_we,
    input  logic [ADDR_W-1:0]         issue_dest,
    input  logic [CNT_W-1:0]          issue_lat,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic                      squash_prev,
`ifdef HAZARD_SCOREBOARD_LLSC_EN
    input  logic                      issue_ll,
    input  logic                      issue_sc,
    input  logic                      link_clear,
    output logic                      sc_fail,
`endif
    output logic                      stall,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic                      issue_accept
);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] load_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic                raw;
    logic                waw;
    logic                dest_ok;
    logic                acc_we;
    logic [CNT_W-1:0]    dest_cnt;
    logic                last_we;
    logic [ADDR_W-1:0]   last_dest;

    // Scanning only real, non-zero registers makes r0 and out-of-range addresses never match.
    always_comb begin
        raw      = 1'b0;
        dest_ok  = 1'b0;
        dest_cnt = '0;
        for (int r = REG_ZERO + 1; r < NUM_REGS; r++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_valid[i] && (src_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) && busy_vec[r]) begin
                    raw = 1'b1;
                end
            end
            if (issue_dest == ADDR_W'(r)) begin
                dest_ok  = 1'b1;
                dest_cnt = cnt[r];
            end
        end
    end

    assign waw          = issue_we && dest_ok && (dest_cnt > issue_lat);
    assign stall        = issue_valid && (raw || waw);
    assign issue_accept = issue_valid && !stall;
    assign acc_we       = issue_accept && issue_we && dest_ok;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cell
        assign load_vec[r] = acc_we && (issue_dest == ADDR_W'(r));
        assign clr_vec[r]  = squash_prev && last_we && (last_dest == ADDR_W'(r));

        hazard_cnt_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr_vec[r]),
            .load     (load_vec[r]),
            .load_val (issue_lat),
            .cnt      (cnt[r]),
            .busy     (busy_vec[r])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_we   <= 1'b0;
            last_dest <= '0;
        end else begin
            last_we   <= acc_we;
            last_dest <= issue_dest;
        end
    end

`ifdef HAZARD_SCOREBOARD_LLSC_EN
    ll_state_t ll_state;

    // A same-cycle link_clear cancels an LL so an exception never leaves a stale link.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ll_state <= LL_IDLE;
        end else begin
            case (ll_state)
                LL_IDLE:   if (issue_accept && issue_ll && !link_clear) ll_state <= LL_LINKED;
                LL_LINKED: if (link_clear || (issue_accept && issue_sc)) ll_state <= LL_IDLE;
            endcase
        end
    end

    assign sc_fail = issue_sc && (ll_state == LL_IDLE);
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, MUL RAW/WAW, squash, r0 and reset cases, plus LL/SC when enabled.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_dest;
    logic [2:0]  issue_lat;
    logic [1:0]  src_valid;
    logic [9:0]  src_addr;
    logic        squash_prev;
    logic        stall;
    logic [31:0] busy_vec;
    logic        issue_accept;
`ifdef HAZARD_SCOREBOARD_LLSC_EN
    logic        issue_ll;
    logic        issue_sc;
    logic        link_clear;
    logic        sc_fail;
`endif

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .NUM_SRC  (2),
        .CNT_W    (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_dest   (issue_dest),
        .issue_lat    (issue_lat),
        .src_valid    (src_valid),
        .src_addr     (src_addr),
        .squash_prev  (squash_prev),
`ifdef HAZARD_SCOREBOARD_LLSC_EN
        .issue_ll     (issue_ll),
        .issue_sc     (issue_sc),
        .link_clear   (link_clear),
        .sc_fail      (sc_fail),
`endif
        .stall        (stall),
        .busy_vec     (busy_vec),
        .issue_accept (issue_accept)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input int dest, input int lat,
                         input logic [1:0] sv, input int s0, input int s1);
        issue_valid = v;
        issue_we    = we;
        issue_dest  = 5'(dest);
        issue_lat   = 3'(lat);
        src_valid   = sv;
        src_addr    = {5'(s1), 5'(s0)};
        #1;
    endtask

    task automatic set_idle();
        squash_prev = 1'b0;
`ifdef HAZARD_SCOREBOARD_LLSC_EN
        issue_ll   = 1'b0;
        issue_sc   = 1'b0;
        link_clear = 1'b0;
`endif
        drive(1'b0, 1'b0, 0, 0, 2'b00, 0, 0);
    endtask

    // Holds current inputs and counts cycles with stall high, bounded.
    task automatic count_stall(output int cnt_out);
        cnt_out = 0;
        while (stall && cnt_out < 20) begin
            cnt_out++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        set_idle();
        tick();
        tick();
        drive(1'b1, 1'b0, 0, 0, 2'b01, 8, 0);
        chk("rst_busy", busy_vec, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_accept", 32'(issue_accept), 1);
        set_idle();
        rst = 1'b1;
        tick();

        // Load-use: lw r8, then add reading r8
        drive(1'b1, 1'b1, 8, LAT_LOAD, 2'b00, 0, 0);
        chk("lw_accept", 32'(issue_accept), 1);
        tick();
        drive(1'b1, 1'b1, 11, LAT_ALU, 2'b01, 8, 0);
        chk("lu_stall_c1", 32'(stall), 1);
        chk("lu_busy8_c1", 32'(busy_vec[8]), 1);
        tick();
        chk("lu_busy8_c2", 32'(busy_vec[8]), 0);
        chk("lu_stall_c2", 32'(stall), 0);
        chk("lu_accept_c2", 32'(issue_accept), 1);
        tick();

        // MUL RAW via source slot 1
        drive(1'b1, 1'b1, 9, LAT_MUL, 2'b00, 0, 0);
        tick();
        drive(1'b1, 1'b1, 11, LAT_ALU, 2'b10, 0, 9);
        count_stall(n);
        chk("mul_raw_stalls", 32'(n), 3);
        chk("mul_raw_accept", 32'(issue_accept), 1);
        tick();

        // MUL then ALU to same dest: WAW
        drive(1'b1, 1'b1, 10, LAT_MUL, 2'b00, 0, 0);
        tick();
        drive(1'b1, 1'b1, 10, LAT_ALU, 2'b00, 0, 0);
        count_stall(n);
        chk("waw_stalls", 32'(n), 3);
        chk("waw_accept", 32'(issue_accept), 1);
        chk("waw_busy10", 32'(busy_vec[10]), 0);
        tick();
        set_idle();
        chk("waw_all_idle", busy_vec, 0);

        // Squash of a load
        drive(1'b1, 1'b1, 5, LAT_LOAD, 2'b00, 0, 0);
        tick();
        squash_prev = 1'b1;
        drive(1'b1, 1'b1, 6, LAT_ALU, 2'b01, 1, 0);
        chk("sq_ld_unrel_stall", 32'(stall), 0);
        tick();
        squash_prev = 1'b0;
        drive(1'b1, 1'b0, 0, 0, 2'b01, 5, 0);
        chk("sq_ld_reader_stall", 32'(stall), 0);
        tick();

        // Squash of a MUL: counter would otherwise still read 2
        drive(1'b1, 1'b1, 5, LAT_MUL, 2'b00, 0, 0);
        tick();
        squash_prev = 1'b1;
        drive(1'b1, 1'b1, 6, LAT_ALU, 2'b01, 1, 0);
        tick();
        squash_prev = 1'b0;
        drive(1'b1, 1'b0, 0, 0, 2'b01, 5, 0);
        chk("sq_mul_reader_stall", 32'(stall), 0);
        chk("sq_mul_busy5", 32'(busy_vec[5]), 0);
        tick();

        // Squash with no write in the previous cycle has no effect
        drive(1'b1, 1'b1, 12, LAT_MUL, 2'b00, 0, 0);
        tick();
        set_idle();
        tick();
        squash_prev = 1'b1;
        tick();
        set_idle();
        chk("sq_nowe_busy12", 32'(busy_vec[12]), 1);
        tick();
        chk("sq_nowe_busy12_end", 32'(busy_vec[12]), 0);

        // Squash and same-register issue together: issue wins; WAW at equal latency is no hazard
        drive(1'b1, 1'b1, 13, LAT_MUL, 2'b00, 0, 0);
        tick();
        squash_prev = 1'b1;
        drive(1'b1, 1'b1, 13, LAT_MUL, 2'b00, 0, 0);
        chk("sq_issue_waw_eq", 32'(stall), 0);
        tick();
        squash_prev = 1'b0;
        drive(1'b1, 1'b0, 0, 0, 2'b01, 13, 0);
        count_stall(n);
        chk("sq_issue_stalls", 32'(n), 3);
        tick();

        // Reissue while counter is decrementing to 0: new value wins
        drive(1'b1, 1'b1, 14, LAT_LOAD, 2'b00, 0, 0);
        tick();
        drive(1'b1, 1'b1, 14, LAT_MUL, 2'b00, 0, 0);
        chk("reissue_stall", 32'(stall), 0);
        tick();
        drive(1'b1, 1'b0, 0, 0, 2'b01, 14, 0);
        count_stall(n);
        chk("reissue_stalls", 32'(n), 3);
        tick();

        // Write to r0 never makes anything busy
        drive(1'b1, 1'b1, 0, LAT_MUL, 2'b00, 0, 0);
        tick();
        drive(1'b1, 1'b0, 0, 0, 2'b11, 0, 0);
        chk("r0_stall", 32'(stall), 0);
        chk("r0_busy", busy_vec, 0);
        tick();
        chk("r0_busy_next", busy_vec, 0);

        // Unread operand does not stall
        drive(1'b1, 1'b1, 7, LAT_MUL, 2'b00, 0, 0);
        tick();
        drive(1'b1, 1'b0, 0, 0, 2'b00, 7, 7);
        chk("srcinv_stall", 32'(stall), 0);
        tick();

        // Reset mid-operation drops all pending counts
        drive(1'b1, 1'b1, 15, LAT_MUL, 2'b00, 0, 0);
        tick();
        rst = 1'b0;
        set_idle();
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 0, 0, 2'b11, 15, 7);
        chk("midrst_busy", busy_vec, 0);
        chk("midrst_stall", 32'(stall), 0);
        tick();
        set_idle();

`ifdef HAZARD_SCOREBOARD_LLSC_EN
        issue_ll = 1'b1;
        drive(1'b1, 1'b0, 0, 0, 2'b00, 0, 0);
        tick();
        issue_ll = 1'b0;
        issue_sc = 1'b1;
        #1;
        chk("llsc_ok", 32'(sc_fail), 0);
        tick();
        chk("sc_no_ll", 32'(sc_fail), 1);
        tick();

        issue_sc = 1'b0;
        issue_ll = 1'b1;
        tick();
        set_idle();
        link_clear = 1'b1;
        tick();
        link_clear = 1'b0;
        issue_sc = 1'b1;
        drive(1'b1, 1'b0, 0, 0, 2'b00, 0, 0);
        chk("ll_clr_sc", 32'(sc_fail), 1);
        tick();

        issue_sc   = 1'b0;
        issue_ll   = 1'b1;
        link_clear = 1'b1;
        tick();
        issue_ll   = 1'b0;
        link_clear = 1'b0;
        issue_sc   = 1'b1;
        #1;
        chk("ll_clr_same_cycle", 32'(sc_fail), 1);
        tick();

        issue_sc = 1'b0;
        issue_ll = 1'b1;
        tick();
        rst = 1'b0;
        set_idle();
        tick();
        rst = 1'b1;
        issue_sc = 1'b1;
        drive(1'b1, 1'b0, 0, 0, 2'b00, 0, 0);
        chk("rst_linked_sc", 32'(sc_fail), 1);
        tick();
        set_idle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
